// File: rtl/mod_chain_pkg.sv
// Shared constants and helpers for the modulo chain counter.
// Optional feature macro: MOD_CHAIN_UPDOWN_EN (enables down counting via dir).
package mod_chain_pkg;

  localparam int MODULUS_DEF    = 13;
  localparam int NUM_STAGES_DEF = 2;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Clamp a loaded digit into the legal 0..modulus-1 range.
  function automatic int sat_mod(input int val, input int modulus);
    return (val >= modulus) ? modulus - 1 : val;
  endfunction

endpackage

// File: rtl/mod_chain_stage.sv
// One modulo-MODULUS digit: parallel load with saturation, single step per
// enabled edge, wrap at the terminal value, terminal flag from the register.
// Optional feature macro: MOD_CHAIN_UPDOWN_EN (adds down counting via dir).
module mod_chain_stage import mod_chain_pkg::*; #(
  parameter  int MODULUS = MODULUS_DEF,
  localparam int WIDTH   = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             at_max;

  assign at_max = (q_q == MAXV);
  assign q      = q_q;

`ifdef MOD_CHAIN_UPDOWN_EN
  logic at_min;
  assign at_min = (q_q == '0);
  // Terminal flag tracks dir combinationally so the chain carry follows it.
  assign tc = (dir == DIR_UP) ? at_max : at_min;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign tc = at_max;
`endif

  // Next digit value: load wins over step, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = WIDTH'(sat_mod(int'(load_val), MODULUS));
    end else if (step) begin
`ifdef MOD_CHAIN_UPDOWN_EN
      if (dir == DIR_UP) q_d = at_max ? '0 : q_q + ONE;
      else               q_d = at_min ? MAXV : q_q - ONE;
`else
      q_d = at_max ? '0 : q_q + ONE;
`endif
    end
  end

  // Digit register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/mod_chain_counter.sv
// Cascade of NUM_STAGES modulo-MODULUS digits, stage 0 least significant.
// A stage steps only when all lower stages sit at their terminal value;
// carry_o flags the cycle before the whole chain wraps.
// Optional feature macro: MOD_CHAIN_UPDOWN_EN (up/down counting via dir).
module mod_chain_counter import mod_chain_pkg::*; #(
  parameter  int MODULUS    = MODULUS_DEF,
  parameter  int NUM_STAGES = NUM_STAGES_DEF,
  localparam int WIDTH      = $clog2(MODULUS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        load,
  input  logic [NUM_STAGES*WIDTH-1:0] load_val,
  input  logic                        dir,
  output logic [NUM_STAGES*WIDTH-1:0] qo,
  output logic [NUM_STAGES-1:0]       tc,
  output logic                        carry_o
);

  logic [NUM_STAGES-1:0]            step;
  logic [NUM_STAGES-1:0][WIDTH-1:0] q_arr;

  // Ripple the enable through the terminal flags; load blocks stepping and
  // reset gates the chain carry. load_val never reaches tc or carry_o.
  always_comb begin
    logic acc;
    step = '0;
    acc  = en & ~load;
    for (int k = 0; k < NUM_STAGES; k++) begin
      step[k] = acc;
      acc     = acc & tc[k];
    end
    carry_o = acc & rst_n;
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    mod_chain_stage #(.MODULUS(MODULUS)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (step[k]),
      .load     (load),
      .load_val (load_val[k*WIDTH +: WIDTH]),
      .dir      (dir),
      .q        (q_arr[k]),
      .tc       (tc[k])
    );
  end

  assign qo = q_arr;

endmodule

// File: doc/mod_chain_counter.md
MOD_CHAIN_COUNTER -- requirements
Module: mod_chain_counter

Interface
REQ-001 SHALL have parameter MODULUS, default 13: count range of each stage, 0 to MODULUS-1; legal range 2..256.
REQ-002 SHALL have parameter NUM_STAGES, default 2: number of cascaded modulo stages; legal range 1..8.
REQ-003 SHALL derive a local constant WIDTH = $clog2(MODULUS) as the bits per stage; it is not overridable.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 SHALL have port load_val, input, NUM_STAGES*WIDTH bits: load value; stage k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port dir, input, 1 bit: count direction, 1 = up and 0 = down; it is used only when MOD_CHAIN_UPDOWN_EN is defined.
REQ-010 SHALL have port qo, output, NUM_STAGES*WIDTH bits: registered stage values, same packing as load_val, with stage 0 least significant.
REQ-011 SHALL have port tc, output, NUM_STAGES bits: per-stage terminal flag, combinational from qo and direction.
REQ-012 SHALL have port carry_o, output, 1 bit: chain overflow/underflow flag, combinational.

Function
REQ-013 SHALL apply this priority at each rising edge of clk: load, then en, then hold.
REQ-014 SHALL, when load=1, write load_val into qo on that edge, with each stage value >= MODULUS saturated to MODULUS-1; en is ignored in that cycle.
REQ-015 SHALL, when en=1 and load=0, step stage 0 by one in the active direction.
REQ-016 SHALL step stage k>0 only when en=1 and tc[j]=1 for every j<k.
REQ-017 SHALL wrap in the up direction: MODULUS-1 goes to 0. SHALL wrap in the down direction: 0 goes to MODULUS-1.
REQ-018 SHALL drive tc[k]=1 while stage k equals the terminal value: MODULUS-1 when counting up, 0 when counting down.
REQ-019 SHALL drive carry_o = en & ~load & (all tc bits = 1), i.e. high in the cycle before the full chain wraps.
REQ-020 SHALL update qo one clock edge after en is sampled; there are no pipeline stages.
REQ-021 SHALL hold qo and leave tc/carry_o consistent with qo when en=0 and load=0.
REQ-022 SHALL, when dir changes while enabled, take effect on the next edge; tc and carry_o follow dir combinationally.
REQ-023 SHALL, when MODULUS is a power of two, count through every WIDTH-bit code; saturation then never occurs.

Reset
REQ-024 SHALL, on rst_n=0, clear qo to all zeros immediately, without waiting for a clock edge.
REQ-025 SHALL, during reset, drive tc to the flags for qo=0 (all ones when counting down, all zeros when counting up) and carry_o to 0 (en is gated by rst_n).
REQ-026 SHALL treat reset asserted mid-count or mid-load as aborting that operation; the first update after release is at the first rising edge with rst_n=1.

Configuration
REQ-027 SHALL, with MOD_CHAIN_UPDOWN_EN defined, honour dir for counting, terminal values and carry_o as specified above.
REQ-028 SHALL, with MOD_CHAIN_UPDOWN_EN undefined, count up only, ignore dir, and contain no down-count logic.

Structure
REQ-029 SHALL place the default constants (MODULUS_DEF=13, NUM_STAGES_DEF=2) and a saturate-to-modulus function in shared package mod_chain_pkg.
REQ-030 SHALL implement each digit as sub-module mod_chain_stage (ports: clk, rst_n, step, load, load_val, dir, q, tc), instantiated NUM_STAGES times in a generate loop.
REQ-031 SHALL contain no latches and no combinational paths from load_val to tc or carry_o.

Verification (MODULUS=13, NUM_STAGES=2, MOD_CHAIN_UPDOWN_EN defined unless stated)
REQ-032 SHALL cover: release reset, en=1, dir=1 for 13 edges -> stage0 steps 0..12 then 0; stage1 reaches 1 on edge 13; tc[0]=1 only while stage0=12.
REQ-033 SHALL cover: en=1 for 169 edges from {0,0} -> qo returns to {0,0}; carry_o=1 in exactly one cycle, at qo={12,12}.
REQ-034 SHALL cover: load=1 and en=1 together with load_val={5,15} -> qo={5,12} (saturated); no increment in that cycle.
REQ-035 SHALL cover: dir=0 from {0,0}, one enabled edge -> qo={12,12}; carry_o=1 before that edge.
REQ-036 SHALL cover: rst_n driven low between edges at qo={7,3} -> qo=0 before the next edge; en=0 for 10 edges after release -> qo stays 0.
REQ-037 SHALL cover: MOD_CHAIN_UPDOWN_EN undefined, dir=0, 3 enabled edges -> qo={0,3} (up count).
